// File: rtl/mac_engine_pkg.sv
// mac_engine shared package: widths, matrix geometry, FSM encoding.
// Everything that sizes the engine lives here so sub-blocks agree.
package mac_engine_pkg;

    localparam int COEF_W   = 7;
    localparam int WORD_W   = 14;
    localparam int ADDR_W   = 4;
    localparam int ROWS     = 8;
    localparam int COLS     = 4;
    localparam int X_W_DEF  = 8;
    localparam int Y_W_DEF  = 18;
    localparam int XCNT_W   = 3;
    localparam int CCNT_W   = 5;
    localparam int OIDX_W   = 2;
    // COMPUTE counts 0..16: 16 address cycles plus one ROM-latency cycle
    localparam int CCNT_END = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_X,
        S_COMPUTE,
        S_OUTPUT
    } state_e;

endpackage

// File: rtl/mac_engine_if.sv
// Stream bundle for mac_engine: X input stream and Y result stream.
// slave = engine side, master = producer/consumer side.
interface mac_engine_if #(
    parameter int X_W = mac_engine_pkg::X_W_DEF,
    parameter int Y_W = mac_engine_pkg::Y_W_DEF
) ();
    logic           x_valid;
    logic [X_W-1:0] x_data;
    logic           x_ready;
    logic           y_valid;
    logic [Y_W-1:0] y_data;
    logic           y_last;
    logic           y_ready;

    modport master (
        output x_valid, x_data, y_ready,
        input  x_ready, y_valid, y_data, y_last
    );

    modport slave (
        input  x_valid, x_data, y_ready,
        output x_ready, y_valid, y_data, y_last
    );
endinterface

// File: rtl/mac_pair.sv
// Dual multiply-add: sum_o = (clr ? 0 : acc) + a0*x0 + a1*x1.
// Ports: clk/rst, en_i/clr_i control, a*_i coeffs, x*_i data, sum_o.
module mac_pair
    import mac_engine_pkg::*;
#(
    parameter int X_W = X_W_DEF,
    parameter int Y_W = Y_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [COEF_W-1:0] a0_i,
    input  logic [COEF_W-1:0] a1_i,
    input  logic [X_W-1:0]    x0_i,
    input  logic [X_W-1:0]    x1_i,
    output logic [Y_W-1:0]    sum_o
);
    logic [Y_W-1:0] acc_q;
    logic [Y_W-1:0] acc_d;
    logic [Y_W-1:0] p0;
    logic [Y_W-1:0] p1;

    assign p0    = Y_W'(a0_i) * Y_W'(x0_i);
    assign p1    = Y_W'(a1_i) * Y_W'(x1_i);
    // clear folds into the first add so a column needs no idle cycle
    assign acc_d = (clr_i ? '0 : acc_q) + p0 + p1;
    assign sum_o = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/mac_engine.sv
// 8x4 coefficient matrix times 8-element X vector, streamed in/out.
// Ports: clk, rst, aload_done, rom_addr/A_input ROM, bus (X/Y streams).
module mac_engine
    import mac_engine_pkg::*;
#(
    parameter int X_W = X_W_DEF,
    parameter int Y_W = Y_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aload_done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] A_input,
    mac_engine_if.slave       bus
);
    state_e              state_q;
    state_e              state_d;
    logic [XCNT_W-1:0]   xcnt_q;
    logic [CCNT_W-1:0]   ccnt_q;
    logic [OIDX_W-1:0]   oidx_q;
    logic [X_W-1:0]      x_q   [ROWS];
    logic [Y_W-1:0]      res_q [COLS];

    logic                x_hs;
    logic                y_hs;
    logic                mac_en;
    logic [ADDR_W-1:0]   widx;
    logic [1:0]          k;
    logic [1:0]          col;
    logic [Y_W-1:0]      sum;

    assign x_hs = bus.x_valid && bus.x_ready;
    assign y_hs = bus.y_valid && bus.y_ready;

    // A_input lags rom_addr by one cycle, so word w arrives at count w+1
    assign mac_en = (state_q == S_COMPUTE) && (ccnt_q != '0);
    assign widx   = ADDR_W'(ccnt_q - CCNT_W'(1));
    assign k      = widx[1:0];
    assign col    = widx[3:2];

    mac_pair #(.X_W(X_W), .Y_W(Y_W)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en_i  (mac_en),
        .clr_i (k == 2'd0),
        .a0_i  (A_input[COEF_W-1:0]),
        .a1_i  (A_input[WORD_W-1:COEF_W]),
        .x0_i  (x_q[{k, 1'b0}]),
        .x1_i  (x_q[{k, 1'b1}]),
        .sum_o (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (aload_done) state_d = S_LOAD_X;
            S_LOAD_X:
                if (x_hs && xcnt_q == '1) state_d = S_COMPUTE;
            S_COMPUTE:
                if (ccnt_q == CCNT_W'(CCNT_END)) state_d = S_OUTPUT;
            S_OUTPUT:
                if (y_hs && oidx_q == '1) state_d = S_LOAD_X;
        endcase
    end

    assign bus.x_ready = (state_q == S_LOAD_X);
    assign bus.y_valid = (state_q == S_OUTPUT);
    assign bus.y_last  = (state_q == S_OUTPUT) && (oidx_q == '1);
    assign bus.y_data  = (state_q == S_OUTPUT) ? res_q[oidx_q] : '0;
    assign rom_addr    = (state_q == S_COMPUTE && !ccnt_q[CCNT_W-1])
                       ? ccnt_q[ADDR_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            xcnt_q <= '0;
            ccnt_q <= '0;
            oidx_q <= '0;
            for (int i = 0; i < ROWS; i++) x_q[i] <= '0;
            for (int i = 0; i < COLS; i++) res_q[i] <= '0;
        end else begin
            // counters wrap to 0 on their last step, ready for next vector
            if (x_hs) begin
                x_q[xcnt_q] <= bus.x_data;
                xcnt_q      <= xcnt_q + 1'b1;
            end
            if (state_q == S_COMPUTE && ccnt_q != CCNT_W'(CCNT_END)) begin
                ccnt_q <= ccnt_q + 1'b1;
            end else begin
                ccnt_q <= '0;
            end
            if (mac_en && k == 2'd3) begin
                res_q[col] <= sum;
            end
            if (y_hs) begin
                oidx_q <= oidx_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mac_engine.sv
// Self-checking bench for mac_engine: table vectors, random vectors,
// output stalls, mid-COMPUTE reset and idle hold.
module tb_mac_engine;
    localparam int XW = 8;
    localparam int YW = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aload_done = 1'b0;
    logic [3:0]  rom_addr;
    logic [13:0] A_input = '0;

    mac_engine_if #(.X_W(XW), .Y_W(YW)) bus ();

    mac_engine #(.X_W(XW), .Y_W(YW)) dut (
        .clk        (clk),
        .rst        (rst),
        .aload_done (aload_done),
        .rom_addr   (rom_addr),
        .A_input    (A_input),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    logic [6:0]  amat [8][4];
    int          xv [8];
    logic [17:0] expy [4];

    typedef struct {
        int           a_kind;
        logic [63:0]  x;
        logic [71:0]  y;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [13:0] rom_word(input logic [3:0] a);
        int c;
        int kk;
        c  = int'(a[3:2]);
        kk = int'(a[1:0]);
        return {amat[2*kk+1][c], amat[2*kk][c]};
    endfunction

    // synchronous ROM with one cycle of read latency
    always @(posedge clk) A_input <= rom_word(rom_addr);

    task automatic check(input string name, input longint act,
                         input longint req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int kind);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 4; c++)
                case (kind)
                    0:       amat[r][c] = 7'(r + 1);
                    1:       amat[r][c] = 7'd127;
                    2:       amat[r][c] = 7'(c + 1);
                    default: amat[r][c] = 7'($urandom_range(0, 127));
                endcase
    endtask

    // reference: plain matrix-vector product
    task automatic model();
        longint s;
        for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int r = 0; r < 8; r++)
                s += longint'(amat[r][c]) * longint'(xv[r]);
            expy[c] = 18'(s);
        end
    endtask

    task automatic load_x();
        int b;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.x_valid = 1'b0;
                tick();
            end
            bus.x_valid = 1'b1;
            bus.x_data  = 8'(xv[i]);
            b = 0;
            while (!bus.x_ready && b < 100) begin
                tick();
                b++;
            end
            if (b >= 100) check("x_ready_timeout", 0, 1);
            tick();
        end
        bus.x_valid = 1'b0;
    endtask

    task automatic compute_phase();
        int cyc;
        int bad;
        cyc = 0;
        bad = 0;
        while (!bus.y_valid && cyc < 100) begin
            if (cyc < 16 && int'(rom_addr) != cyc) bad++;
            if (bus.x_ready) bad++;
            bus.x_valid = 1'($urandom_range(0, 1));
            bus.x_data  = 8'($urandom_range(0, 255));
            tick();
            cyc++;
        end
        bus.x_valid = 1'b0;
        check("compute_cycles", cyc, 17);
        check("compute_addr_seq", bad, 0);
    endtask

    task automatic drain(input bit stall);
        int          b;
        int          unstable;
        logic [17:0] prev;
        bit          done;
        unstable = 0;
        for (int j = 0; j < 4; j++) begin
            b = 0;
            done = 1'b0;
            while (!done && b < 200) begin
                bus.y_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.y_valid && bus.y_ready) begin
                    check($sformatf("y_data[%0d]", j), bus.y_data, expy[j]);
                    check($sformatf("y_last[%0d]", j), bus.y_last, j == 3);
                    tick();
                    done = 1'b1;
                end else begin
                    prev = bus.y_data;
                    tick();
                    if (bus.y_valid && bus.y_data !== prev) unstable++;
                end
                b++;
            end
            if (!done) check("y_timeout", 0, 1);
        end
        bus.y_ready = 1'b0;
        check("y_stable_in_stall", unstable, 0);
        check("back_to_load_x", bus.x_ready, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_x_ready"}, bus.x_ready, 0);
        check({tag, "_y_valid"}, bus.y_valid, 0);
        check({tag, "_y_data"}, bus.y_data, 0);
        check({tag, "_y_last"}, bus.y_last, 0);
    endtask

    initial begin
        int bad;
        bus.x_valid = 1'b0;
        bus.x_data  = '0;
        bus.y_ready = 1'b0;
        set_a(0);

        vecs[0] = '{0, {8{8'd1}}, {4{18'd36}}};
        vecs[1] = '{0, {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                    {4{18'd204}}};
        vecs[2] = '{1, {8{8'd255}}, {4{18'd259080}}};
        vecs[3] = '{2, {8{8'd1}},
                    {18'd32, 18'd24, 18'd16, 18'd8}};

        tick();
        tick();
        check_outputs_zero("reset");

        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            bus.x_valid = 1'($urandom_range(0, 1));
            tick();
            if (bus.x_ready || rom_addr != 4'd0) bad++;
        end
        bus.x_valid = 1'b0;
        check("idle_hold", bad, 0);

        aload_done = 1'b1;
        tick();
        aload_done = 1'b0;

        for (int v = 0; v < 4; v++) begin
            set_a(vecs[v].a_kind);
            for (int i = 0; i < 8; i++) xv[i] = int'(vecs[v].x[i*8 +: 8]);
            for (int c = 0; c < 4; c++) expy[c] = vecs[v].y[c*18 +: 18];
            load_x();
            compute_phase();
            drain(v[0]);
        end

        for (int v = 0; v < 6; v++) begin
            set_a(3);
            for (int i = 0; i < 8; i++) xv[i] = $urandom_range(0, 255);
            model();
            load_x();
            compute_phase();
            drain(1'b1);
        end

        set_a(0);
        for (int i = 0; i < 8; i++) xv[i] = i + 1;
        load_x();
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs_zero("mid_reset");
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.x_ready || bus.y_valid) bad++;
        end
        check("post_reset_idle", bad, 0);

        aload_done = 1'b1;
        tick();
        aload_done = 1'b0;
        for (int c = 0; c < 4; c++) expy[c] = 18'd204;
        load_x();
        compute_phase();
        drain(1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mac_engine.md
MAC_ENGINE -- requirements
Module: mac_engine

Interface
REQ-001 SHALL have parameters: X_W, default 8, input element width (unsigned); Y_W, default 18, result width.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port aload_done, input, 1, coefficient ROM loaded (level).
REQ-005 SHALL have port rom_addr, output, 4, coefficient ROM read address.
REQ-006 SHALL have port A_input, input, 14, ROM word, registered one cycle after rom_addr.
REQ-007 SHALL have ports x_valid (input, 1), x_data (input, X_W) and x_ready (output, 1), forming the input-vector stream.
REQ-008 SHALL have ports y_valid (output, 1), y_data (output, Y_W), y_last (output, 1) and y_ready (input, 1), forming the result stream.

Function
REQ-009 SHALL treat the coefficients as an 8-row x 4-column unsigned 7-bit matrix A; word at addr = col*4+k holds A[2k][col] in bits [6:0] and A[2k+1][col] in bits [13:7].
REQ-010 SHALL compute Y[c] = sum over r=0..7 of A[r][c]*X[r], for c=0..3, unsigned, full precision: 7x8 product 15b, 8-term sum 18b, no saturation.
REQ-011 SHALL implement states IDLE, LOAD_X, COMPUTE, OUTPUT.
REQ-012 SHALL, in IDLE, hold x_ready=0 and move to LOAD_X on the first cycle aload_done=1; aload_done is ignored once IDLE is left.
REQ-013 SHALL, in LOAD_X, assert x_ready=1, store x_data into X[0..7] in arrival order on each x_valid&&x_ready cycle, and go to COMPUTE after the 8th transfer.
REQ-014 SHALL, in COMPUTE, drive rom_addr 0..15 on 16 consecutive cycles and perform two MACs per returned word (one-cycle ROM latency), so COMPUTE lasts exactly 17 cycles.
REQ-015 SHALL clear the accumulator at the first word of each column and latch Y[c] into a 4-entry result register after its 4th word.
REQ-016 SHALL, in OUTPUT, present Y[0]..Y[3] in order with y_valid=1; y_data and y_last stay stable until y_valid&&y_ready; y_last=1 only with Y[3].
REQ-017 SHALL return to LOAD_X (not IDLE) after the Y[3] handshake; a y_ready held at 1 drains all four results in 4 cycles.
REQ-018 SHALL keep x_ready=0 outside LOAD_X and y_valid=0 outside OUTPUT; x_valid outside LOAD_X is ignored and not stored.
REQ-019 SHALL hold rom_addr at 0 outside COMPUTE.

Reset
REQ-020 SHALL, when rst=1 in any state, including mid-LOAD_X, mid-COMPUTE or a pending y_valid, go to IDLE on the next edge, discard partial X and accumulator contents, and lose any pending result.
REQ-021 SHALL reset the outputs to rom_addr=0, x_ready=0, y_valid=0, y_data=0 and y_last=0, and clear the X store, accumulator, result registers and counters to 0.

Structure
REQ-022 SHALL take the widths (coefficient 7, ROM word 14, address 4, X_W, Y_W), the row/column counts (8/4) and the state encoding from the shared project package.
REQ-023 SHALL place the dual multiply-add (two 7xX_W products plus accumulator) in one sub-module, mac_pair, with the FSM and counters in mac_engine.

Verification
REQ-024 SHALL pass: A[r][c]=r+1 for all c, X all 1 -> Y = 36,36,36,36; y_last on the 4th.
REQ-025 SHALL pass: same A, X = 1..8 -> every Y = 204; COMPUTE measured at exactly 17 cycles.
REQ-026 SHALL pass: all A=127, X all 255 -> every Y = 259080, with no overflow in 18b.
REQ-027 SHALL pass: y_ready toggling 0/1 with random stalls -> y_data is stable while stalled and no result is dropped or duplicated; x_valid pulses during COMPUTE are ignored.
REQ-028 SHALL pass: rst asserted at the 5th COMPUTE cycle -> next cycle IDLE with all outputs 0; after aload_done a fresh X = 1..8 yields 204 for each Y.
REQ-029 SHALL pass: aload_done held 0 for 50 cycles -> x_ready stays 0 and rom_addr stays 0.
